usb_resp_tx: RTL and testbench
==============================

Name: usb_resp_tx

Overview:
- Builds fixed 6-word response/status frames and pushes them into the USB upload FIFO, i.e. the write side feeding `usb_stream_in`. Frames travel FPGA→PC.
- This is the transmit counterpart of the USB command decoder, which turns PC→FPGA words into addr/data/cmdvalid. This block turns an (addr, data) response into a framed 16-bit word stream the host can parse.
- It runs in the clk50m domain, alongside `state_ctrl`.

Parameters:
- FIFO_DEPTH, 2048, depth in words of the USB upload FIFO.
- USEDW_MAX, 2040, a frame may start only when usb_fifo_usedw <= USEDW_MAX. Must be <= FIFO_DEPTH-6.
- HEADER, 16'h55A5, frame word 0.
- TAIL, 16'hAA5A, frame word 5.

Ports:
- clk50m  in  1  system clock, 50 MHz
- Rst_n  in  1  asynchronous active-low reset
- resp_valid  in  1  response request
- resp_ready  out  1  block can accept a request
- resp_addr  in  8  register address being reported
- resp_data  in  32  register value being reported
- usb_fifo_usedw  in  11  upload FIFO fill level
- usb_fifo_wrreq  out  1  FIFO write strobe
- usb_fifo_wrdata  out  16  FIFO write data
- frame_busy  out  1  high from accept until the frame completes
- frame_done  out  1  one-cycle pulse after the last word is written
- frame_cnt  out  16  count of completed frames, wraps

Behaviour:
- Reset: Rst_n is asynchronous, active-low; clock is clk50m. Reset values:
  - state=IDLE, resp_ready=1
  - usb_fifo_wrreq=0, usb_fifo_wrdata=0
  - frame_busy=0, frame_done=0, frame_cnt=0
  - internal seq[7:0]=0
- Handshake: accept when resp_valid && resp_ready on a rising edge.
  - resp_addr and resp_data are latched on that edge.
  - resp_ready is high only in IDLE and drops the cycle after accept.
  - resp_valid while not ready is ignored. The requester must hold its request until it is accepted.
- IDLE: on accept, go to WAIT_SPACE and set frame_busy=1.
- WAIT_SPACE: each cycle, if usb_fifo_usedw <= USEDW_MAX go to SEND with idx=0, otherwise stay. No timeout.
- SEND: usb_fifo_wrreq=1 for exactly 6 consecutive cycles, idx 0..5. Data is registered in the same cycle as wrreq. Words in order:
  - idx0: HEADER
  - idx1: {seq, addr}
  - idx2: data[31:16]
  - idx3: data[15:0]
  - idx4: csum = (w1 + w2 + w3) mod 2^16
  - idx5: TAIL
- Flow control: no stall inside SEND. usb_fifo_usedw is sampled only in WAIT_SPACE, and USEDW_MAX guarantees room for the whole frame.
- DONE (1 cycle):
  - wrreq=0, frame_done=1
  - frame_cnt increments (0xFFFF wraps to 0)
  - seq increments (0xFF wraps to 0)
  - frame_busy=0
  - next state IDLE, where resp_ready=1
- Latency:
  - First wrreq is 2 cycles after the accept edge when space is available (1 cycle in WAIT_SPACE).
  - resp_ready returns 9 cycles after accept.
- usb_fifo_wrdata holds its last value when wrreq=0.
- Reset mid-frame: wrreq deasserts immediately (asynchronously) and the partial frame is abandoned. seq and frame_cnt return to 0. The host resynchronises on HEADER.
- The seq value used in a frame is the value at accept time.
- usedw exactly USEDW_MAX: start allowed. USEDW_MAX+1: wait.

Test Plan:
- Basic frame: reset, usedw=0, addr=8'h03, data=32'h12345678.
  - Writes 55A5, 0003, 1234, 5678, 68AF, AA5A on 6 consecutive wrreq cycles.
  - First wrreq 2 cycles after accept, frame_done 1 cycle after the last word, frame_cnt=1.
- Checksum overflow: run 255 frames so seq=8'hFF, then send addr=FF, data=FFFFFFFF.
  - Words 55A5, FFFF, FFFF, FFFF, FFFD, AA5A.
  - Next frame's word1 high byte is 8'h00.
- Backpressure: hold usedw=2041 for 20 cycles after accept.
  - No wrreq; frame_busy=1; resp_ready=0.
  - Drop usedw to 2040: SEND begins on the next cycle.
- Back-to-back: resp_valid held high for 3 requests.
  - Exactly 3 frames, 18 wrreq cycles, separated by DONE/IDLE/WAIT_SPACE gaps.
  - seq values 0, 1, 2; frame_cnt=3.
- Ignored request: pulse resp_valid during SEND.
  - No extra frame; the in-flight frame's data is unchanged.
- Reset mid-frame: assert Rst_n=0 at idx2.
  - wrreq=0 immediately; resp_ready=1, frame_cnt=0 after release.
  - The next frame's word1 high byte is 00.

Source files
------------

// File: rtl/usb_resp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : usb_resp_tx
//  Purpose  : Packs an (addr, data) register response into a fixed 6-word
//             frame (HEADER, {seq,addr}, data_hi, data_lo, csum, TAIL) and
//             writes it into the USB upload FIFO feeding usb_stream_in.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_resp_tx #(
    parameter int          FIFO_DEPTH = 2048,
    parameter int          USEDW_MAX  = 2040,
    parameter logic [15:0] HEADER     = 16'h55A5,
    parameter logic [15:0] TAIL       = 16'hAA5A
) (
    input  logic        clk50m,
    input  logic        Rst_n,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [7:0]  resp_addr,
    input  logic [31:0] resp_data,
    input  logic [10:0] usb_fifo_usedw,
    output logic        usb_fifo_wrreq,
    output logic [15:0] usb_fifo_wrdata,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    // A frame is never stalled once started, so the start threshold must
    // leave room for all six words; clamp a mis-set USEDW_MAX to be safe.
    localparam int          c_LIMIT_INT   = (USEDW_MAX > FIFO_DEPTH - 6) ? (FIFO_DEPTH - 6) : USEDW_MAX;
    localparam logic [10:0] c_USEDW_LIMIT = c_LIMIT_INT[10:0];
    localparam logic [2:0]  c_LAST_IDX    = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_SPACE = 2'd1,
        S_SEND       = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [2:0]  idx_q,    idx_d;
    logic [7:0]  addr_q,   addr_d;
    logic [31:0] data_q,   data_d;
    logic [7:0]  seq_q,    seq_d;
    logic        wrreq_q,  wrreq_d;
    logic [15:0] wrdata_q, wrdata_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic [15:0] cnt_q,    cnt_d;

    logic [2:0]  w_sel_idx;
    logic [15:0] w_word1;
    logic [15:0] w_csum;
    logic [15:0] w_next_word;

    assign resp_ready      = (state_q == S_IDLE);
    assign usb_fifo_wrreq  = wrreq_q;
    assign usb_fifo_wrdata = wrdata_q;
    assign frame_busy      = busy_q;
    assign frame_done      = done_q;
    assign frame_cnt       = cnt_q;

    // seq_q only advances in DONE, so during a frame it still holds the
    // value that was current when the request was accepted.
    assign w_word1   = {seq_q, addr_q};
    assign w_csum    = w_word1 + data_q[31:16] + data_q[15:0];
    // Index of the word to be presented on the next cycle.
    assign w_sel_idx = (state_q == S_SEND) ? (idx_q + 3'd1) : 3'd0;

    // Frame word selected for the next write.
    always_comb begin
        w_next_word = TAIL;
        case (w_sel_idx)
            3'd0:    w_next_word = HEADER;
            3'd1:    w_next_word = w_word1;
            3'd2:    w_next_word = data_q[31:16];
            3'd3:    w_next_word = data_q[15:0];
            3'd4:    w_next_word = w_csum;
            default: w_next_word = TAIL;
        endcase
    end

    // Next-state and registered-output logic for the framing FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        seq_d    = seq_q;
        wrreq_d  = 1'b0;
        wrdata_d = wrdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (resp_valid) begin
                    addr_d  = resp_addr;
                    data_d  = resp_data;
                    busy_d  = 1'b1;
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (usb_fifo_usedw <= c_USEDW_LIMIT) begin
                    state_d  = S_SEND;
                    idx_d    = 3'd0;
                    wrreq_d  = 1'b1;
                    wrdata_d = w_next_word;
                end
            end
            S_SEND: begin
                if (idx_q == c_LAST_IDX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    seq_d   = seq_q + 8'd1;
                end else begin
                    idx_d    = idx_q + 3'd1;
                    wrreq_d  = 1'b1;
                    wrdata_d = w_next_word;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame at once.
    always_ff @(posedge clk50m or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            addr_q   <= 8'd0;
            data_q   <= 32'd0;
            seq_q    <= 8'd0;
            wrreq_q  <= 1'b0;
            wrdata_q <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            seq_q    <= seq_d;
            wrreq_q  <= wrreq_d;
            wrdata_q <= wrdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_resp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_resp_tx
//  Purpose  : Self-checking bench for usb_resp_tx with a word scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_resp_tx;

    logic        clk50m = 1'b0;
    logic        Rst_n  = 1'b0;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [7:0]  resp_addr = 8'd0;
    logic [31:0] resp_data = 32'd0;
    logic [10:0] usb_fifo_usedw = 11'd0;
    logic        usb_fifo_wrreq;
    logic [15:0] usb_fifo_wrdata;
    logic        frame_busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    usb_resp_tx dut (
        .clk50m          (clk50m),
        .Rst_n           (Rst_n),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_addr       (resp_addr),
        .resp_data       (resp_data),
        .usb_fifo_usedw  (usb_fifo_usedw),
        .usb_fifo_wrreq  (usb_fifo_wrreq),
        .usb_fifo_wrdata (usb_fifo_wrdata),
        .frame_busy      (frame_busy),
        .frame_done      (frame_done),
        .frame_cnt       (frame_cnt)
    );

    always #10 clk50m = ~clk50m;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  m_seq = 8'd0;
    int          n_wr = 0, n_done = 0, widx = 0;
    int          first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0, acc_cyc = 0;
    logic [15:0] last_w1 = 16'd0;

    always @(posedge clk50m) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every FIFO write is popped from the scoreboard and compared.
    always @(negedge clk50m) begin
        if (!Rst_n) begin
            widx = 0;
        end else begin
            if (usb_fifo_wrreq) begin
                if (exp_q.size() == 0) chk("unexpected_wr", {31'd0, usb_fifo_wrreq}, 32'd0);
                else                   chk("wrdata", {16'd0, usb_fifo_wrdata}, {16'd0, exp_q.pop_front()});
                chk("busy_in_send", {31'd0, frame_busy}, 32'd1);
                if (widx == 0) first_wr_cyc = cyc;
                if (widx == 1) last_w1 = usb_fifo_wrdata;
                last_wr_cyc = cyc;
                widx++;
                n_wr++;
            end
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
                chk("words_in_frame", widx, 6);
                chk("wr_span", last_wr_cyc - first_wr_cyc, 5);
                chk("done_gap", done_cyc - last_wr_cyc, 1);
                widx = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk50m);
        #1;
    endtask

    task automatic push_lit(input logic [15:0] a, b, c, d, e, f);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        exp_q.push_back(d); exp_q.push_back(e); exp_q.push_back(f);
        m_seq = m_seq + 8'd1;
    endtask

    task automatic push_frame(input logic [7:0] addr, input logic [31:0] data);
        logic [15:0] w1;
        w1 = {m_seq, addr};
        push_lit(16'h55A5, w1, data[31:16], data[15:0],
                 w1 + data[31:16] + data[15:0], 16'hAA5A);
    endtask

    // Raise a request and return at the sample point just after it is taken.
    task automatic send_req(input logic [7:0] addr, input logic [31:0] data, input bit keep);
        int t;
        resp_addr  = addr;
        resp_data  = data;
        resp_valid = 1'b1;
        t = 0;
        while (!resp_ready && t < 200) begin
            tick();
            t++;
        end
        if (t == 200) chk("ready_timeout", {31'd0, resp_ready}, 32'd1);
        tick();
        acc_cyc = cyc;
        if (!keep) resp_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (n_done < target && t < 200) begin
            tick();
            t++;
        end
        chk("done_count", n_done, target);
    endtask

    task automatic run_frame(input logic [7:0] addr, input logic [31:0] data);
        int n0;
        n0 = n_done;
        push_frame(addr, data);
        send_req(addr, data, 1'b0);
        wait_done(n0 + 1);
    endtask

    task automatic do_reset();
        resp_valid = 1'b0;
        Rst_n      = 1'b0;
        exp_q.delete();
        m_seq = 8'd0;
        repeat (3) tick();
        Rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, t;
        // Reset values
        do_reset();
        chk("rst_ready",  {31'd0, resp_ready}, 32'd1);
        chk("rst_wrreq",  {31'd0, usb_fifo_wrreq}, 32'd0);
        chk("rst_wrdata", {16'd0, usb_fifo_wrdata}, 32'd0);
        chk("rst_busy",   {31'd0, frame_busy}, 32'd0);
        chk("rst_done",   {31'd0, frame_done}, 32'd0);
        chk("rst_cnt",    {16'd0, frame_cnt}, 32'd0);

        // Basic frame with latency checks
        push_lit(16'h55A5, 16'h0003, 16'h1234, 16'h5678, 16'h68AF, 16'hAA5A);
        send_req(8'h03, 32'h12345678, 1'b0);
        wait_done(1);
        chk("first_wr_edge", first_wr_cyc + 1 - acc_cyc, 2);
        t = 0;
        while (!resp_ready && t < 20) begin tick(); t++; end
        chk("ready_return_edge", cyc + 1 - acc_cyc, 9);
        chk("cnt_basic", {16'd0, frame_cnt}, 32'd1);

        // Fill up to seq = 0xFF, then the checksum-overflow frame
        for (int i = 0; i < 254; i++) run_frame(8'($urandom), $urandom);
        chk("cnt_255", {16'd0, frame_cnt}, 32'd255);
        n0 = n_done;
        push_lit(16'h55A5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFD, 16'hAA5A);
        send_req(8'hFF, 32'hFFFFFFFF, 1'b0);
        wait_done(n0 + 1);
        run_frame(8'h11, 32'hA5A5_0F0F);
        chk("seq_wrap_hi", {24'd0, last_w1[15:8]}, 32'd0);
        chk("cnt_257", {16'd0, frame_cnt}, 32'd257);

        // Backpressure: one over the limit holds the frame, the limit releases it
        tick();
        usb_fifo_usedw = 11'd2041;
        n0 = n_done;
        push_frame(8'h5A, 32'hDEAD_BEEF);
        send_req(8'h5A, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("bp_wrreq", {31'd0, usb_fifo_wrreq}, 32'd0);
            chk("bp_busy",  {31'd0, frame_busy}, 32'd1);
            chk("bp_ready", {31'd0, resp_ready}, 32'd0);
            tick();
        end
        usb_fifo_usedw = 11'd2040;
        tick();
        chk("bp_send_start", {31'd0, usb_fifo_wrreq}, 32'd1);
        wait_done(n0 + 1);
        usb_fifo_usedw = 11'd0;

        // Back-to-back with resp_valid held high
        do_reset();
        n0 = n_done;
        t  = n_wr;
        push_frame(8'h10, 32'h0000_0001);
        send_req(8'h10, 32'h0000_0001, 1'b1);
        push_frame(8'h20, 32'h8000_0002);
        send_req(8'h20, 32'h8000_0002, 1'b1);
        push_frame(8'h30, 32'h7FFF_FFFF);
        send_req(8'h30, 32'h7FFF_FFFF, 1'b0);
        wait_done(n0 + 3);
        chk("b2b_wr_cycles", n_wr - t, 18);
        chk("b2b_cnt", {16'd0, frame_cnt}, 32'd3);

        // Ignored request during SEND
        n0 = n_done;
        push_frame(8'h44, 32'h0BAD_F00D);
        send_req(8'h44, 32'h0BAD_F00D, 1'b0);
        t = 0;
        while (widx < 2 && t < 50) begin tick(); t++; end
        resp_addr  = 8'h99;
        resp_data  = 32'h9999_9999;
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        wait_done(n0 + 1);
        repeat (15) tick();
        chk("ign_no_extra", n_done, n0 + 1);
        chk("ign_queue_empty", exp_q.size(), 0);
        chk("ign_cnt", {16'd0, frame_cnt}, 32'd4);

        // Reset in the middle of a frame
        push_frame(8'h77, 32'h1357_9BDF);
        send_req(8'h77, 32'h1357_9BDF, 1'b0);
        t = 0;
        while (widx < 3 && t < 50) begin tick(); t++; end
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_wrreq", {31'd0, usb_fifo_wrreq}, 32'd0);
        exp_q.delete();
        m_seq = 8'd0;
        tick();
        tick();
        Rst_n = 1'b1;
        tick();
        chk("rst_mid_ready", {31'd0, resp_ready}, 32'd1);
        chk("rst_mid_cnt", {16'd0, frame_cnt}, 32'd0);
        run_frame(8'h01, 32'h0000_FFFF);
        chk("rst_mid_seq_hi", {24'd0, last_w1[15:8]}, 32'd0);
        chk("rst_mid_cnt_after", {16'd0, frame_cnt}, 32'd1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
